// File: rtl/pan_pkg.sv
// Shared types and constants for the stereo panner: FSM states, pan range
// limits and the pan-target clamp.
package pan_pkg;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      SLEW  = 3'd1,
      MUL_L = 3'd2,
      MUL_R = 3'd3,
      DONE  = 3'd4
   } pan_state_t;

   localparam logic [15:0] PAN_CENTER = 16'h4000;
   localparam logic [15:0] PAN_MAX    = 16'h7FFF;

   // Pan words above hard-right are treated as hard-right.
   function automatic logic [15:0] clamp_pan(input logic [15:0] pan);
      return (pan > PAN_MAX) ? PAN_MAX : pan;
   endfunction

endpackage

// File: rtl/pan_slew.sv
// Slew-limited pan register: moves toward the target by at most STEP per
// enabled cycle, starting from centre after reset.
module pan_slew
   import pan_pkg::*;
#(
   parameter int          DW   = 16,
   parameter logic [15:0] STEP = 16'h0040
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          en,
   input  logic [DW-1:0] target,
   output logic [DW-1:0] pan
);

   logic [DW-1:0] s_reg;
   logic [DW-1:0] s_next;
   logic [DW:0]   s_ext;
   logic [DW:0]   t_ext;
   logic [DW:0]   step_ext;

   // One extra bit so s + STEP and target + STEP never wrap.
   assign s_ext    = {1'b0, s_reg};
   assign t_ext    = {1'b0, target};
   assign step_ext = {1'b0, STEP[DW-1:0]};

   always_comb begin
      s_next = target;
      if (t_ext > s_ext + step_ext)
         s_next = s_reg + STEP[DW-1:0];
      else if (t_ext + step_ext < s_ext)
         s_next = s_reg - STEP[DW-1:0];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         s_reg <= PAN_CENTER[DW-1:0];
      else if (en)
         s_reg <= s_next;
   end

   assign pan = s_reg;

endmodule

// File: rtl/stereo_panner.sv
// Mono-to-stereo panner: latches a sample and pan target, slews the pan, then
// computes left/right gains with one shared signed multiplier.
module stereo_panner
   import pan_pkg::*;
#(
   parameter int          DW        = 16,
   parameter logic [15:0] SLEW_STEP = 16'h0040
) (
   input  logic          CLOCK_50,
   input  logic          RESET,
   input  logic          SAMPLE_VALID,
   input  logic [DW-1:0] SAMPLE_IN,
   input  logic [DW-1:0] AUTO_PAN,
   input  logic          PAN_EN,
   output logic [DW-1:0] L_OUT,
   output logic [DW-1:0] R_OUT,
   output logic          OUT_VALID,
   output logic          BUSY,
   output logic          OVERRUN
);

   pan_state_t           state_reg;
   logic [DW-1:0]        sample_reg;
   logic [DW-1:0]        target_reg;
   logic [DW-1:0]        l_reg;
   logic [DW-1:0]        r_reg;
   logic [DW-1:0]        pan;
   logic [DW-1:0]        gain;
   logic signed [2*DW-1:0] mul_a;
   logic signed [2*DW-1:0] mul_b;
   logic signed [2*DW-1:0] product;
   logic [DW-1:0]        result;

   pan_slew #(
      .DW   (DW),
      .STEP (SLEW_STEP)
   ) u_slew (
      .clk    (CLOCK_50),
      .rst_n  (RESET),
      .en     (state_reg == SLEW),
      .target (target_reg),
      .pan    (pan)
   );

   // Left gain is the complement of the pan position; pan never exceeds 0x7FFF.
   assign gain    = (state_reg == MUL_L) ? (PAN_MAX[DW-1:0] - pan) : pan;
   assign mul_a   = {{DW{sample_reg[DW-1]}}, sample_reg};
   assign mul_b   = {{DW{1'b0}}, gain};
   assign product = mul_a * mul_b;
   assign result  = DW'(product >>> 15);

   assign BUSY = (state_reg != IDLE);

   always_ff @(posedge CLOCK_50 or negedge RESET) begin
      if (!RESET) begin
         state_reg  <= IDLE;
         sample_reg <= '0;
         target_reg <= PAN_CENTER[DW-1:0];
         l_reg      <= '0;
         r_reg      <= '0;
         L_OUT      <= '0;
         R_OUT      <= '0;
         OUT_VALID  <= 1'b0;
         OVERRUN    <= 1'b0;
      end else begin
         OUT_VALID <= 1'b0;
         if (SAMPLE_VALID && state_reg != IDLE)
            OVERRUN <= 1'b1;
         case (state_reg)
            IDLE: begin
               if (SAMPLE_VALID) begin
                  sample_reg <= SAMPLE_IN;
                  target_reg <= PAN_EN ? clamp_pan(AUTO_PAN) : PAN_CENTER[DW-1:0];
                  state_reg  <= SLEW;
               end
            end
            SLEW:  state_reg <= MUL_L;
            MUL_L: begin
               l_reg     <= result;
               state_reg <= MUL_R;
            end
            MUL_R: begin
               r_reg     <= result;
               state_reg <= DONE;
            end
            DONE: begin
               L_OUT     <= l_reg;
               R_OUT     <= r_reg;
               OUT_VALID <= 1'b1;
               state_reg <= IDLE;
            end
            default: state_reg <= IDLE;
         endcase
      end
   end

endmodule

// File: doc/stereo_panner.md
# stereo_panner

Consumes the 16-bit pan position produced by the auto-panner LFO stage (0x0000 = hard left, 0x4000 = centre, 0x7FFF = hard right) together with the mono voice/mix sample stream and produces a left/right stereo sample pair. The pan position is slew-limited once per sample to suppress zipper noise. A single shared signed multiplier is time-multiplexed by a small FSM. The outputs feed the codec/DAC serialiser.

## Interface
- `DW`, 16: sample and pan word width.
- `SLEW_STEP`, 16'h0040: maximum change of the internal pan value per accepted sample.
- `CLOCK_50` in 1: system clock.
- `RESET` in 1: asynchronous, active-low reset.
- `SAMPLE_VALID` in 1: one-cycle strobe; `SAMPLE_IN` is valid.
- `SAMPLE_IN` in DW: signed two's-complement mono sample.
- `AUTO_PAN` in DW: unsigned pan target. Values above 0x7FFF are clamped to 0x7FFF.
- `PAN_EN` in 1: 1 = track `AUTO_PAN`; 0 = target is centre 0x4000.
- `L_OUT` out DW: signed left sample, registered.
- `R_OUT` out DW: signed right sample, registered.
- `OUT_VALID` out 1: one-cycle pulse when `L_OUT`/`R_OUT` update.
- `BUSY` out 1: high whenever the FSM is not in IDLE.
- `OVERRUN` out 1: sticky flag; a `SAMPLE_VALID` arrived while `BUSY`.

## Operation
- **FSM states:** IDLE → SLEW → MUL_L → MUL_R → DONE → IDLE.
  - **IDLE:** on `SAMPLE_VALID`, latch `SAMPLE_IN` and the clamped target, then go to SLEW. The target is `AUTO_PAN` if `PAN_EN`, else 0x4000.
  - **SLEW:** update the pan register `s`:
    - if target > s + SLEW_STEP: s += SLEW_STEP;
    - else if target + SLEW_STEP < s: s -= SLEW_STEP;
    - else s = target.
    - Comparisons are done at DW+1 bits, so they cannot wrap. `s` is always in the range 0..0x7FFF.
  - **MUL_L:** product = sample × (0x7FFF − s). Signed DW × unsigned 15-bit gives a 32-bit signed product. Result = product[30:15] (arithmetic shift right by 15, truncation toward −∞).
  - **MUL_R:** same calculation using gain s.
  - **DONE:** register `L_OUT`/`R_OUT` and pulse `OUT_VALID`.
- **No overflow:** gain ≤ 0x7FFF < 1.0, so the magnitude of the result never exceeds the input. No saturation logic is required.
- **Busy drops:** a `SAMPLE_VALID` in any non-IDLE state is dropped and sets `OVERRUN`. `OVERRUN` clears only on reset.
- **Holding outputs:** `L_OUT`/`R_OUT` hold their values between `OUT_VALID` pulses.
- **Pan sampling point:** `AUTO_PAN` and `PAN_EN` are sampled only at acceptance in IDLE. Changes at any other time have no effect until the next sample.

## Timing
- **Reset values:** state = IDLE; s = 0x4000; `L_OUT` = `R_OUT` = 0; `OUT_VALID` = `BUSY` = `OVERRUN` = 0.
- **Reset mid-operation:** the FSM aborts immediately. No `OUT_VALID` is issued for the in-flight sample.
- **Latency:** `SAMPLE_VALID` seen at edge 0 gives `OUT_VALID` high in the cycle after edge 4 (fixed 4 cycles).
- **BUSY:** high from the cycle after acceptance through the DONE cycle inclusive.
- **Throughput:** minimum `SAMPLE_VALID` spacing is 5 cycles. A strobe in the cycle immediately after DONE (state IDLE) is accepted.
- **Simultaneous events:**
  - A `SAMPLE_VALID` coinciding with DONE is dropped and sets `OVERRUN`.
  - In that same cycle, `OUT_VALID` still pulses for the previous sample.
- **Slew rate:** `s` changes only in SLEW, at most once per accepted sample.

## Structure
- **Package `pan_pkg`:**
  - state enum `pan_state_t`;
  - constants `PAN_CENTER` = 16'h4000 and `PAN_MAX` = 16'h7FFF;
  - function `clamp_pan`.
- **Sub-module `pan_slew`:** holds the `s` register, the target compare, and step logic, with an update-enable input. It is reset to `PAN_CENTER`.
- **Top level:** the FSM, the sample latch, the single shared multiplier (gain mux selects 0x7FFF − s or s), and the output registers.

## Test plan
- **Reset values:** reset asserted mid-MUL_L → `OUT_VALID` stays 0. After release, all outputs are 0 and the first processed sample uses s = 0x4000.
- **Centre pan:** `PAN_EN` = 0, `SAMPLE_IN` = 0x7FFF → `L_OUT` = 0x3FFE, `R_OUT` = 0x3FFF, with `OUT_VALID` exactly 4 cycles after the strobe.
- **Slew to hard right:** `PAN_EN` = 1, `AUTO_PAN` = 0x7FFF, strobes every 8 cycles. Expect s = 0x7FC0 after 255 samples and 0x7FFF after 256. Then `SAMPLE_IN` = 0x8000 → `R_OUT` = 0x8001, `L_OUT` = 0x0000.
- **Input clamp:** `AUTO_PAN` = 0xFFFF behaves identically to 0x7FFF.
- **Overrun:** strobes at edge 0 and edge 2 → second sample dropped, `OVERRUN` = 1, exactly one `OUT_VALID`. A strobe at edge 5 is accepted.
- **Negative and zero input:** `SAMPLE_IN` = 0xFFFF (−1) at centre → both outputs 0xFFFF (truncation toward −∞). `SAMPLE_IN` = 0 → both outputs 0.
